// File: rtl/mux_select_sequencer.sv
// mux_select_sequencer: feeds a behavioural mux with a held parallel word and
// steps the mux select through every input index, one index per enabled cycle.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   en         clock enable for bit stepping (low stalls the sequence)
//   in_valid   parallel word available
//   in_ready   sequencer accepts a word this cycle (combinational)
//   in_word    parallel word, 2**SELECT_LINES bits
//   data_word  registered held word, drives mux data_in
//   select     registered index, drives mux select
//   bit_valid  mux output is a valid serial bit this cycle (combinational)
//   bit_last   current bit is the final bit of the word (combinational)
//   busy       a word is being sequenced
//
// Build option: define MUX_SELECT_SEQUENCER_MSB_FIRST_EN for MSB-first order
// (select counts down from 2**SELECT_LINES-1 to 0). Default is LSB first.

module mux_select_sequencer #(
   parameter string       BLOCK_NAME   = "mux_select_sequencer",
   parameter int          X            = 0,
   parameter int          Y            = 0,
   parameter int          DX           = 0,
   parameter int          DY           = 0,
   parameter int unsigned SELECT_LINES = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [(2**SELECT_LINES)-1:0]  in_word,
   output logic [(2**SELECT_LINES)-1:0]  data_word,
   output logic [SELECT_LINES-1:0]       select,
   output logic                          bit_valid,
   output logic                          bit_last,
   output logic                          busy
);

   localparam int unsigned WORD_W = 2**SELECT_LINES;

`ifdef MUX_SELECT_SEQUENCER_MSB_FIRST_EN
   localparam logic [SELECT_LINES-1:0] SEL_START = '1;
   localparam logic [SELECT_LINES-1:0] SEL_END   = '0;
`else
   localparam logic [SELECT_LINES-1:0] SEL_START = '0;
   localparam logic [SELECT_LINES-1:0] SEL_END   = '1;
`endif

   // Elaboration sanity checks on configuration.
   if (SELECT_LINES < 1 || SELECT_LINES > 8) begin : g_bad_select_lines
      $error("%s: SELECT_LINES must be in 1..8", BLOCK_NAME);
   end
   if (X < 0 || Y < 0 || DX < 0 || DY < 0) begin : g_bad_placement
      $error("%s: placement values must be non-negative", BLOCK_NAME);
   end

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t                    state, state_next;
   logic [WORD_W-1:0]         word_next;
   logic [SELECT_LINES-1:0]   select_next;
   logic                      at_end;

   assign at_end = (select == SEL_END);

   // State, held word and select registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         data_word <= '0;
         select    <= '0;
         busy      <= 1'b0;
      end else begin
         state     <= state_next;
         data_word <= word_next;
         select    <= select_next;
         busy      <= (state_next == SHIFT);
      end
   end

   // Next-state, handshake and serial-bit qualifiers.
   always_comb begin
      state_next  = state;
      word_next   = data_word;
      select_next = select;
      in_ready    = 1'b0;
      bit_valid   = 1'b0;
      bit_last    = 1'b0;

      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               word_next   = in_word;
               select_next = SEL_START;
               state_next  = SHIFT;
            end
         end
         SHIFT: begin
            bit_valid = en;
            bit_last  = en && at_end;
            if (en) begin
               if (at_end) begin
                  // Last bit: a waiting word is taken with no bubble cycle.
                  in_ready = 1'b1;
                  if (in_valid) begin
                     word_next   = in_word;
                     select_next = SEL_START;
                  end else begin
                     state_next  = IDLE;
                  end
               end else begin
`ifdef MUX_SELECT_SEQUENCER_MSB_FIRST_EN
                  select_next = select - SELECT_LINES'(1);
`else
                  select_next = select + SELECT_LINES'(1);
`endif
               end
            end
         end
      endcase
   end

endmodule

// File: doc/mux_select_sequencer.md
Name: mux_select_sequencer

Overview:
- Upstream feeder for the behavioural `mux` primitive: accepts a parallel word (2**SELECT_LINES bits) over a valid/ready handshake.
- Holds the word stable on `data_word` and steps `select` through every input index, one per enabled cycle.
- Downstream `mux` turns the held word into a serial bit stream. Used for bit-serial readout and serialisation paths.

Parameters:
- BLOCK_NAME, "mux_select_sequencer", hierarchical block name
- X, 0, x location within sub-block
- Y, 0, y location within sub-block
- DX, 0, x length
- DY, 0, y length
- SELECT_LINES, 4, width of `select`; word width is 2**SELECT_LINES; legal range 1..8

Ports:
- clk  input  1  system clock, all logic rising-edge
- rst  input  1  asynchronous, active-high reset
- en  input  1  clock enable for bit stepping; held low stalls the sequence
- in_valid  input  1  parallel word available
- in_ready  output  1  sequencer can accept a word this cycle
- in_word  input  2**SELECT_LINES  parallel word
- data_word  output  2**SELECT_LINES  registered word, drives mux `data_in`
- select  output  SELECT_LINES  registered index, drives mux `select`
- bit_valid  output  1  mux output is a valid serial bit this cycle
- bit_last  output  1  current bit is the final bit of the word
- busy  output  1  a word is being sequenced (state SHIFT)

Behaviour:
Reset values:
- rst high (async): state=IDLE; data_word=0; select=0; bit_valid=0; bit_last=0; busy=0; in_ready=1 (combinational, see below).
- Reset mid-word discards the word; no partial completion after release.

State IDLE:
- in_ready=1.
- If in_valid, capture in_word into data_word, load select=START, go to SHIFT.
- en is ignored in IDLE.

State SHIFT:
- busy=1.
- bit_valid = en (combinational from en, registered select/data_word).
- bit_last = en && (select==END).
- With en=1 and select!=END: select advances one step toward END.
- With en=0: select and data_word hold; bit_valid=0, bit_last=0.
- With en=1 and select==END:
  - If in_valid: capture the new word, select=START, stay in SHIFT. This gives back-to-back words with no bubble.
  - Otherwise go to IDLE. select holds END; data_word holds.

Handshake:
- in_ready = (state==IDLE) || (state==SHIFT && en && select==END). This is combinational.
- A transfer occurs on in_valid && in_ready at the rising edge.
- in_word must be stable only in the accepting cycle.

Ordering and indices:
- Default order is LSB first: START=0, END=2**SELECT_LINES-1, step +1.
- select never wraps within a word. Exactly 2**SELECT_LINES bit_valid cycles occur per accepted word.

Latency:
- Word accepted at edge t. First bit_valid is in cycle t+1 if en=1.
- Minimum word period is 2**SELECT_LINES cycles, with en held high and a back-to-back supply.

Simultaneous events:
- in_valid while busy and not on the last bit: not accepted (in_ready=0). Upstream holds the word.
- en falls on the last-bit cycle: no completion and no acceptance. Completion happens on the next en=1 cycle.

Optional Feature:
MUX_SELECT_SEQUENCER_MSB_FIRST_EN
- Defined: MSB-first order. START=2**SELECT_LINES-1, END=0, step -1. select's post-word hold value is 0.
- Undefined: LSB-first order as above.
- All handshake, latency and bit-count rules are unchanged in both modes.

Test Plan:
1. SELECT_LINES=2, en=1, accept in_word=4'b1011 -> select 0,1,2,3 in cycles t+1..t+4; mux bits 1,1,0,1; bit_last only at select=3; in_ready=1 at t+4; IDLE at t+5.
2. Back-to-back: 4'hB then 4'h6 with in_valid held high -> 8 consecutive bit_valid cycles; bits 1,1,0,1,0,1,1,0; single in_ready pulse at first word's select=3.
3. Stall: en low for 3 cycles while select=1 -> select, data_word hold; bit_valid=0; resumes at select=2; total bit_valid count stays 4.
4. Reset mid-word: rst pulse asynchronously at select=2 -> outputs immediately 0, in_ready=1; next accepted word starts at select=0.
5. in_valid asserted at select=1 -> in_ready=0, no capture; word accepted only at select=3 with en=1.
6. MSB_FIRST_EN defined, SELECT_LINES=3, word 8'h81 -> select 7..0; bits 1,0,0,0,0,0,0,1; bit_last at select=0.
